// File: rtl/occ_pkg.sv
// Shared definitions for the room occupancy counter: direction FSM states,
// synchroniser depth and the two-bit beam patterns {A, B}.
package occ_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A1     = 3'd1,
    AB_IN  = 3'd2,
    B_TAIL = 3'd3,
    B1     = 3'd4,
    BA_OUT = 3'd5,
    A_TAIL = 3'd6
  } occ_state_t;

  localparam int OCC_SYNC_STAGES = 2;

  // Beam patterns as {outer A, inner B}
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_A    = 2'b10;
  localparam logic [1:0] PAT_B    = 2'b01;
  localparam logic [1:0] PAT_AB   = 2'b11;

endpackage

// File: rtl/occ_debounce.sv
// Single-bit sensor conditioner: OCC_SYNC_STAGES-flop synchroniser followed,
// when ROOM_DEBOUNCE_EN is defined, by a debouncer that only moves its output
// after the synchronised input has disagreed with it for DEB_CYC consecutive
// cycles. Without ROOM_DEBOUNCE_EN the synchroniser output is passed through
// and DEB_CYC has no effect.
module occ_debounce
  import occ_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (DEB_CYC < 1) begin : g_bad_deb_cyc
    $error("occ_debounce: DEB_CYC must be at least 1");
  end

  logic [OCC_SYNC_STAGES-1:0] sync_q;
  logic                       din_sync;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[OCC_SYNC_STAGES-2:0], din};
    end
  end

  assign din_sync = sync_q[OCC_SYNC_STAGES-1];

`ifdef ROOM_DEBOUNCE_EN
  // Run counter only needs to reach DEB_CYC-1: the DEB_CYC-th differing
  // cycle flips the output directly.
  localparam int            RUN_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYC - 1);

  logic [RUN_W-1:0] run_q;
  logic             deb_q;

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= '0;
      deb_q <= 1'b0;
    end else if (din_sync != deb_q) begin
      if (run_q == RUN_LAST) begin
        deb_q <= din_sync;
        run_q <= '0;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end else begin
      run_q <= '0;
    end
  end

  assign dout = deb_q;
`else
  assign dout = din_sync;
`endif

endmodule

// File: rtl/room_occupancy_counter.sv
// Two-beam room occupancy counter. Outer beam A and inner beam B are
// conditioned by occ_debounce, a direction FSM recognises complete entry
// (A, AB, B, none) and exit (B, AB, A, none) walks, and a saturating counter
// tracks occupancy with a sticky over/underflow flag.
// Optional feature: define ROOM_DEBOUNCE_EN to debounce both beams.
module room_occupancy_counter
  import occ_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_COUNT = 2**CNT_W - 1,
  parameter int DEB_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_a,
  input  logic             sensor_b,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             empty,
  output logic             full,
  output logic             ovf_err
);

  if (MAX_COUNT < 1 || MAX_COUNT > 2**CNT_W - 1) begin : g_bad_max_count
    $error("room_occupancy_counter: MAX_COUNT out of range 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);

  // Saturating step functions: never wrap past MAX_CNT or below zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_CNT) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  logic       beam_a;
  logic       beam_b;
  logic [1:0] pat;

  occ_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sensor_a),
    .dout  (beam_a)
  );

  occ_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sensor_b),
    .dout  (beam_b)
  );

  assign pat = {beam_a, beam_b};

  occ_state_t state_q;
  logic       amb_q;    // both beams seen together while idle: wait for clear
  logic       entry_done;
  logic       exit_done;

  // A walk completes when its tail state sees both beams clear
  assign entry_done = (state_q == B_TAIL) && (pat == PAT_NONE);
  assign exit_done  = (state_q == A_TAIL) && (pat == PAT_NONE);

  // Direction FSM: advance along a walk, step back one state on a reversal,
  // abandon to IDLE on clear beams or any pattern that does not fit the walk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      amb_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (amb_q) begin
            if (pat == PAT_NONE) amb_q <= 1'b0;
          end else begin
            case (pat)
              PAT_A:   state_q <= A1;
              PAT_B:   state_q <= B1;
              PAT_AB:  amb_q   <= 1'b1;
              default: state_q <= IDLE;
            endcase
          end
        end
        A1: begin
          case (pat)
            PAT_AB:  state_q <= AB_IN;
            PAT_A:   state_q <= A1;
            default: state_q <= IDLE;
          endcase
        end
        AB_IN: begin
          case (pat)
            PAT_B:   state_q <= B_TAIL;
            PAT_A:   state_q <= A1;
            PAT_AB:  state_q <= AB_IN;
            default: state_q <= IDLE;
          endcase
        end
        B_TAIL: begin
          case (pat)
            PAT_AB:  state_q <= AB_IN;
            PAT_B:   state_q <= B_TAIL;
            default: state_q <= IDLE;
          endcase
        end
        B1: begin
          case (pat)
            PAT_AB:  state_q <= BA_OUT;
            PAT_B:   state_q <= B1;
            default: state_q <= IDLE;
          endcase
        end
        BA_OUT: begin
          case (pat)
            PAT_A:   state_q <= A_TAIL;
            PAT_B:   state_q <= B1;
            PAT_AB:  state_q <= BA_OUT;
            default: state_q <= IDLE;
          endcase
        end
        A_TAIL: begin
          case (pat)
            PAT_AB:  state_q <= BA_OUT;
            PAT_A:   state_q <= A_TAIL;
            default: state_q <= IDLE;
          endcase
        end
        default: begin
          state_q <= IDLE;
          amb_q   <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy counter, event strobes and sticky error; clear wins over an
  // event in the same cycle but the event strobe is still emitted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      entry_pulse <= entry_done;
      exit_pulse  <= exit_done;
      if (clear) begin
        count   <= '0;
        ovf_err <= 1'b0;
      end else if (entry_done) begin
        if (count == MAX_CNT) ovf_err <= 1'b1;
        count <= sat_inc(count);
      end else if (exit_done) begin
        if (count == '0) ovf_err <= 1'b1;
        count <= sat_dec(count);
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == MAX_CNT);

endmodule

// File: tb/tb_room_occupancy_counter.sv
// Directed + randomised bench for room_occupancy_counter. A reference model
// describes each direction as an ordered list of beam patterns and tracks the
// position along it; occupancy is plain integer arithmetic with clamping.
module tb_room_occupancy_counter;
  import occ_pkg::*;

  localparam int CNT_W     = 3;
  localparam int MAX_COUNT = 5;
  localparam int DEB_CYC   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sensor_a;
  logic             sensor_b;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic             entry_pulse;
  logic             exit_pulse;
  logic             empty;
  logic             full;
  logic             ovf_err;

  always #5 clk = ~clk;

  room_occupancy_counter #(
    .CNT_W     (CNT_W),
    .MAX_COUNT (MAX_COUNT),
    .DEB_CYC   (DEB_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .clear       (clear),
    .count       (count),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .empty       (empty),
    .full        (full),
    .ovf_err     (ovf_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic m_s1a, m_s2a, m_s1b, m_s2b;   // two-stage synchroniser history
  logic m_da, m_db;                   // debounced levels
  int   m_ra, m_rb;                   // debounce run lengths
  int   m_dir;                        // 0 = entering, 1 = leaving
  int   m_idx;                        // position along the walk, 0 = idle
  bit   m_amb;
  int   m_count;
  bit   m_ent, m_ext, m_ovf;

  int ent_seen, ext_seen;
  bit a1_seen;

  // Ordered beam patterns {A,B} of each walk, index 0 = both clear
  function automatic logic [1:0] path_pat(int dir, int k);
    logic [1:0] p;
    case (k % 4)
      0: p = 2'b00;
      1: p = (dir == 0) ? 2'b10 : 2'b01;
      2: p = 2'b11;
      default: p = (dir == 0) ? 2'b01 : 2'b10;
    endcase
    return p;
  endfunction

  function automatic occ_state_t model_state();
    occ_state_t s;
    if (m_idx == 0)      s = IDLE;
    else if (m_dir == 0) s = (m_idx == 1) ? A1 : (m_idx == 2) ? AB_IN : B_TAIL;
    else                 s = (m_idx == 1) ? B1 : (m_idx == 2) ? BA_OUT : A_TAIL;
    return s;
  endfunction

  function automatic logic [1:0] model_pat();
`ifdef ROOM_DEBOUNCE_EN
    return {m_da, m_db};
`else
    return {m_s2a, m_s2b};
`endif
  endfunction

  task automatic deb_update(inout logic lvl, inout int run, input logic in);
    if (in != lvl) begin
      run = run + 1;
      if (run >= DEB_CYC) begin
        lvl = in;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    logic [1:0] p;
    bit ev_in, ev_out;
    if (!rst_n) begin
      {m_s1a, m_s2a, m_s1b, m_s2b, m_da, m_db} = '0;
      m_ra = 0; m_rb = 0; m_dir = 0; m_idx = 0; m_amb = 0;
      m_count = 0; m_ent = 0; m_ext = 0; m_ovf = 0;
      return;
    end
    p = model_pat();
    ev_in = 0; ev_out = 0;
    if (m_idx == 0) begin
      if (m_amb) begin
        if (p == 2'b00) m_amb = 0;
      end else if (p == 2'b11) m_amb = 1;
      else if (p == 2'b10) begin m_dir = 0; m_idx = 1; end
      else if (p == 2'b01) begin m_dir = 1; m_idx = 1; end
    end else if (p == path_pat(m_dir, m_idx)) begin
      // holding the current pattern
    end else if (p == path_pat(m_dir, m_idx + 1)) begin
      if (m_idx == 3) begin
        if (m_dir == 0) ev_in = 1; else ev_out = 1;
        m_idx = 0;
      end else m_idx = m_idx + 1;
    end else if (p == path_pat(m_dir, m_idx - 1)) begin
      m_idx = m_idx - 1;
    end else begin
      m_idx = 0;
    end
    m_ent = ev_in;
    m_ext = ev_out;
    if (clear) begin
      m_count = 0; m_ovf = 0;
    end else if (ev_in) begin
      if (m_count == MAX_COUNT) m_ovf = 1; else m_count = m_count + 1;
    end else if (ev_out) begin
      if (m_count == 0) m_ovf = 1; else m_count = m_count - 1;
    end
`ifdef ROOM_DEBOUNCE_EN
    deb_update(m_da, m_ra, m_s2a);
    deb_update(m_db, m_rb, m_s2b);
`endif
    m_s2a = m_s1a; m_s1a = sensor_a;
    m_s2b = m_s1b; m_s1b = sensor_b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: step model, let DUT clock, compare on the falling edge
  task automatic cycle_chk();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (entry_pulse === 1'b1) ent_seen++;
    if (exit_pulse === 1'b1) ext_seen++;
    if (dut.state_q == A1) a1_seen = 1;
    check("count", 32'(count), 32'(m_count));
    check("entry_pulse", 32'(entry_pulse), 32'(m_ent));
    check("exit_pulse", 32'(exit_pulse), 32'(m_ext));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("full", 32'(full), 32'(m_count == MAX_COUNT));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check("state", 32'(dut.state_q), 32'(model_state()));
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) cycle_chk();
  endtask

  task automatic do_entry(input int h);
    hold(1, 0, h); hold(1, 1, h); hold(0, 1, h); hold(0, 0, h);
  endtask

  task automatic do_exit(input int h);
    hold(0, 1, h); hold(1, 1, h); hold(1, 0, h); hold(0, 0, h);
  endtask

  initial begin
    bit hit;
    int mode, h;
    rst_n = 0; sensor_a = 0; sensor_b = 0; clear = 0;
    ent_seen = 0; ext_seen = 0; a1_seen = 0;
    @(negedge clk);
    repeat (2) cycle_chk();
    rst_n = 1;

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Single entry, each level held 10 cycles
    ent_seen = 0;
    do_entry(10);
    check("entry_pulses", 32'(ent_seen), 32'd1);
    check("entry_count", 32'(count), 32'd1);
    check("entry_empty", 32'(empty), 32'd0);

    // Saturation: seven more entries, ceiling 5
    for (int i = 2; i <= 8; i++) begin
      do_entry(10);
      if (i == 5) check("sat_no_ovf_yet", 32'(ovf_err), 32'd0);
      if (i == 6) check("sat_ovf_6th", 32'(ovf_err), 32'd1);
    end
    check("sat_pulses", 32'(ent_seen), 32'd8);
    check("sat_count", 32'(count), 32'd5);
    check("sat_full", 32'(full), 32'd1);

    // Down to 4, error stays sticky
    do_exit(10);
    check("exit_count4", 32'(count), 32'd4);
    check("exit_ovf_sticky", 32'(ovf_err), 32'd1);

    // Clear in the exact cycle an exit completes
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10);
    sensor_a = 0; sensor_b = 0;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (m_idx == 3 && model_pat() == 2'b00) begin
        clear = 1;
        cycle_chk();
        clear = 0;
        hit = 1;
      end else begin
        cycle_chk();
      end
    end
    check("clr_window", 32'(hit), 32'd1);
    check("clr_count", 32'(count), 32'd0);
    check("clr_exit_pulse", 32'(exit_pulse), 32'd1);
    check("clr_ovf", 32'(ovf_err), 32'd0);
    hold(0, 0, 4);

    // Exit back-out from count 3
    repeat (3) do_entry(10);
    ent_seen = 0; ext_seen = 0;
    hold(0, 1, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
    check("backout_pulses", 32'(ent_seen + ext_seen), 32'd0);
    check("backout_count", 32'(count), 32'd3);

    // Reset for one cycle while in AB_IN, then finish the entry pattern
    hold(1, 0, 10); hold(1, 1, 10);
    check("mid_in_ab", 32'(dut.state_q), 32'(AB_IN));
    rst_n = 0;
    cycle_chk();
    rst_n = 1;
    ent_seen = 0;
    hold(0, 1, 10); hold(0, 0, 10);
    check("mid_no_entry", 32'(ent_seen), 32'd0);
    check("mid_count", 32'(count), 32'd0);

    // Three-cycle glitch on A
    a1_seen = 0;
    hold(1, 0, 3); hold(0, 0, 12);
`ifdef ROOM_DEBOUNCE_EN
    check("glitch_a1", 32'(a1_seen), 32'd0);
`else
    check("glitch_a1", 32'(a1_seen), 32'd1);
`endif

    // Randomised traffic with occasional clears and resets
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 3);
      h = $urandom_range(1, 8);
      clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) rst_n = 0;
      cycle_chk();
      clear = 0;
      rst_n = 1;
      case (mode)
        0: hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h);
        1: do_entry(h);
        2: do_exit(h);
        default: begin
          hold(1, 0, h); hold(1, 1, h); hold(1, 0, h); hold(0, 0, h);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
